// File: rtl/ex_mem_wb_bypass_source_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_wb_bypass_source_pkg
// Description : Shared types and constants for the EX/MEM -> MEM/WB bypass
//               source slice. It holds the default datapath widths, the
//               load-FSM state encoding and the MEM/WB record with its bubble
//               value.
// Revision    : 1.0 - initial release
// ============================================================================
package ex_mem_wb_bypass_source_pkg;

    localparam int C_DATA_W = 32;
    localparam int C_REG_AW = 5;

    typedef enum logic [0:0] {
        LS_IDLE = 1'b0,
        LS_WAIT = 1'b1
    } load_state_t;

    typedef struct packed {
        logic                regwrite;
        logic [C_REG_AW-1:0] regwriteaddr;
        logic [C_DATA_W-1:0] aluresult;
        logic [C_DATA_W-1:0] memreaddata;
        logic                memtoreg;
    } mem_wb_t;

    // A bubble never writes back and carries no data.
    localparam mem_wb_t C_MEM_WB_BUBBLE = '{
        regwrite:     1'b0,
        regwriteaddr: '0,
        aluresult:    '0,
        memreaddata:  '0,
        memtoreg:     1'b0
    };

    // Register-file write data selected from a MEM/WB record.
    function automatic logic [C_DATA_W-1:0] wb_select(input mem_wb_t rec);
        return rec.memtoreg ? rec.memreaddata : rec.aluresult;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_mem_load_fsm.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_load_fsm
// Description : Single-outstanding load handshake controller for the EX/MEM
//               stage. It issues a one-cycle request for a load sitting in
//               EX/MEM, stalls the front of the pipeline until the read data
//               returns, and flags the cycle the data is captured.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_isload        - EX/MEM holds a load
//               i_rvalid        - memory read data valid
//               o_mem_req       - load request strobe
//               o_mem_stall     - hold EX/MEM and everything upstream
//               o_capture       - read data is valid for the load this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_load_fsm
    import ex_mem_wb_bypass_source_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_isload,
    input  logic i_rvalid,
    output logic o_mem_req,
    output logic o_mem_stall,
    output logic o_capture
);

    load_state_t r_state;
    load_state_t w_state_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LS_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_mem_req    = 1'b0;
        o_mem_stall  = 1'b0;
        o_capture    = 1'b0;
        case (r_state)
            LS_IDLE: begin
                // The request goes out the first cycle the load is in EX/MEM;
                // a zero-latency response lets it advance without stalling.
                if (i_isload) begin
                    o_mem_req = 1'b1;
                    if (i_rvalid) begin
                        o_capture = 1'b1;
                    end else begin
                        o_mem_stall  = 1'b1;
                        w_state_next = LS_WAIT;
                    end
                end
            end
            LS_WAIT: begin
                if (i_rvalid) begin
                    o_capture    = 1'b1;
                    w_state_next = LS_IDLE;
                end else begin
                    o_mem_stall = 1'b1;
                end
            end
            default: begin
                w_state_next = LS_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ex_mem_wb_bypass_source.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_wb_bypass_source
// Description : Producer end of the ID-stage forwarding network. Registers the
//               EX result through EX/MEM and MEM/WB, publishes every bypass
//               source, performs loads over a single-outstanding data-memory
//               handshake, stalls the front of the pipeline while a load is
//               pending and drives the register-file write port.
// Ports       : clk, rst                      - clock, sync active-high reset
//               EX_*                          - instruction leaving EX
//               mem_req/mem_addr              - load request
//               mem_rvalid/mem_rdata          - load response
//               mem_stall                     - hold PC/IF/ID/EX
//               EX_MEM_*, MEM_WB_*            - bypass sources
//               rf_we/rf_waddr/rf_wdata       - register-file write port
// Options     : BYPASS_ZERO_SUPPRESS_EN - strip writes to register 0 at
//               EX/MEM capture so $0 is never forwarded or written.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_wb_bypass_source
    import ex_mem_wb_bypass_source_pkg::*;
#(
    parameter int DATA_W = C_DATA_W,
    parameter int REG_AW = C_REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              EX_valid,
    input  logic              EX_regwrite,
    input  logic [REG_AW-1:0] EX_regwriteaddr,
    input  logic [DATA_W-1:0] EX_aluresult,
    input  logic              EX_memread,
    output logic              mem_req,
    output logic [DATA_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_stall,
    output logic              EX_MEM_regwrite,
    output logic [REG_AW-1:0] EX_MEM_regwriteaddr,
    output logic [DATA_W-1:0] EX_MEM_regwritedata,
    output logic              EX_MEM_isload,
    output logic              MEM_WB_regwrite,
    output logic [REG_AW-1:0] MEM_WB_regwriteaddr,
    output logic [DATA_W-1:0] MEM_WB_aluresult,
    output logic [DATA_W-1:0] MEM_WB_memreaddata,
    output logic              MEM_WB_memtoreg,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    // The MEM/WB record type is sized by the package widths.
    if (DATA_W != C_DATA_W || REG_AW != C_REG_AW) begin : g_width_check
        $error("ex_mem_wb_bypass_source: DATA_W/REG_AW must match the package");
    end

    logic              r_exm_regwrite;
    logic [REG_AW-1:0] r_exm_addr;
    logic [DATA_W-1:0] r_exm_data;
    logic              r_exm_isload;
    mem_wb_t           r_mwb;
    mem_wb_t           w_mwb_next;

    logic              w_regwrite_in;
    logic              w_mem_req;
    logic              w_mem_stall;
    logic              w_capture;

`ifdef BYPASS_ZERO_SUPPRESS_EN
    assign w_regwrite_in = EX_valid & EX_regwrite & (EX_regwriteaddr != '0);
`else
    assign w_regwrite_in = EX_valid & EX_regwrite;
`endif

    ex_mem_load_fsm u_load_fsm (
        .clk         (clk),
        .rst         (rst),
        .i_isload    (r_exm_isload),
        .i_rvalid    (mem_rvalid),
        .o_mem_req   (w_mem_req),
        .o_mem_stall (w_mem_stall),
        .o_capture   (w_capture)
    );

    // EX/MEM: advances whenever the load FSM is not holding it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_exm_regwrite <= 1'b0;
            r_exm_addr     <= '0;
            r_exm_data     <= '0;
            r_exm_isload   <= 1'b0;
        end else if (!w_mem_stall) begin
            r_exm_regwrite <= w_regwrite_in;
            r_exm_addr     <= EX_regwriteaddr;
            r_exm_data     <= EX_aluresult;
            r_exm_isload   <= EX_valid & EX_memread;
        end
    end

    // MEM/WB takes a bubble while EX/MEM is held so a stalled instruction
    // writes back once, on the cycle it finally advances.
    always_comb begin
        w_mwb_next = C_MEM_WB_BUBBLE;
        if (!w_mem_stall) begin
            w_mwb_next.regwrite     = r_exm_regwrite;
            w_mwb_next.regwriteaddr = r_exm_addr;
            w_mwb_next.aluresult    = r_exm_data;
            w_mwb_next.memreaddata  = w_capture ? mem_rdata : '0;
            w_mwb_next.memtoreg     = r_exm_isload;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mwb <= C_MEM_WB_BUBBLE;
        end else begin
            r_mwb <= w_mwb_next;
        end
    end

    // EX/MEM is held throughout a pending load, so its data doubles as the
    // stable load address.
    assign mem_req   = w_mem_req;
    assign mem_addr  = r_exm_isload ? r_exm_data : '0;
    assign mem_stall = w_mem_stall;

    assign EX_MEM_regwrite     = r_exm_regwrite;
    assign EX_MEM_regwriteaddr = r_exm_addr;
    assign EX_MEM_regwritedata = r_exm_data;
    assign EX_MEM_isload       = r_exm_isload;

    assign MEM_WB_regwrite     = r_mwb.regwrite;
    assign MEM_WB_regwriteaddr = r_mwb.regwriteaddr;
    assign MEM_WB_aluresult    = r_mwb.aluresult;
    assign MEM_WB_memreaddata  = r_mwb.memreaddata;
    assign MEM_WB_memtoreg     = r_mwb.memtoreg;

    assign rf_we    = r_mwb.regwrite;
    assign rf_waddr = r_mwb.regwriteaddr;
    assign rf_wdata = wb_select(r_mwb);

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_wb_bypass_source.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_mem_wb_bypass_source
// Description : Scoreboard bench for ex_mem_wb_bypass_source. The driver acts
//               as the upstream pipeline and as a data memory with random
//               latency; expected requests and writebacks are queued when an
//               instruction is accepted and popped by an independent monitor.
//               Honours BYPASS_ZERO_SUPPRESS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mem_wb_bypass_source;

    localparam int DW = 32;
    localparam int AW = 5;
`ifdef BYPASS_ZERO_SUPPRESS_EN
    localparam bit ZS = 1'b1;
`else
    localparam bit ZS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          EX_valid = 1'b0, EX_regwrite = 1'b0, EX_memread = 1'b0;
    logic [AW-1:0] EX_regwriteaddr = '0;
    logic [DW-1:0] EX_aluresult = '0;
    logic          mem_req, mem_stall, mem_rvalid = 1'b0;
    logic [DW-1:0] mem_addr, mem_rdata = '0;
    logic          EX_MEM_regwrite, EX_MEM_isload;
    logic [AW-1:0] EX_MEM_regwriteaddr;
    logic [DW-1:0] EX_MEM_regwritedata;
    logic          MEM_WB_regwrite, MEM_WB_memtoreg;
    logic [AW-1:0] MEM_WB_regwriteaddr;
    logic [DW-1:0] MEM_WB_aluresult, MEM_WB_memreaddata;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;

    ex_mem_wb_bypass_source dut (
        .clk(clk), .rst(rst),
        .EX_valid(EX_valid), .EX_regwrite(EX_regwrite),
        .EX_regwriteaddr(EX_regwriteaddr), .EX_aluresult(EX_aluresult),
        .EX_memread(EX_memread),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_stall(mem_stall),
        .EX_MEM_regwrite(EX_MEM_regwrite), .EX_MEM_regwriteaddr(EX_MEM_regwriteaddr),
        .EX_MEM_regwritedata(EX_MEM_regwritedata), .EX_MEM_isload(EX_MEM_isload),
        .MEM_WB_regwrite(MEM_WB_regwrite), .MEM_WB_regwriteaddr(MEM_WB_regwriteaddr),
        .MEM_WB_aluresult(MEM_WB_aluresult), .MEM_WB_memreaddata(MEM_WB_memreaddata),
        .MEM_WB_memtoreg(MEM_WB_memtoreg),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic          v, rw, mr;
        logic [AW-1:0] ra;
        logic [DW-1:0] alu;
    } instr_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          m2r;
        int            at_cyc;
        bit            exact;
    } wb_t;

    instr_t        instr_q[$];
    wb_t           wb_q[$];
    logic [DW-1:0] req_q[$];
    instr_t        cur;
    bit            need_new = 1'b1;

    // Expected EX/MEM contents (the last accepted instruction).
    logic          exp_rw = 1'b0, exp_ld = 1'b0;
    logic [AW-1:0] exp_ra = '0;
    logic [DW-1:0] exp_rd = '0;

    // Memory model state.
    bit            pend = 1'b0;
    logic [DW-1:0] pend_addr = '0;
    int            pend_cnt = 0;
    int            force_lat = -1;
    bit            mem_auto = 1'b1;
    bit            late_rv = 1'b0;
    int            stall_cnt = 0;

    int checks = 0;
    int errors = 0;

    function automatic logic [DW-1:0] mem_fn(input logic [DW-1:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic instr_t mk(input logic v, input logic rw, input logic [AW-1:0] ra,
                                  input logic [DW-1:0] alu, input logic mr);
        instr_t i;
        i.v = v; i.rw = rw; i.ra = ra; i.alu = alu; i.mr = mr;
        return i;
    endfunction

    function automatic instr_t rand_instr(input bit allow_valid);
        instr_t i;
        i.v   = allow_valid && ($urandom_range(0, 9) != 0);
        i.rw  = ($urandom_range(0, 3) != 0);
        i.ra  = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
        i.alu = $urandom;
        i.mr  = ($urandom_range(0, 4) < 2);
        return i;
    endfunction

    task automatic apply_cur();
        EX_valid        = cur.v;
        EX_regwrite     = cur.rw;
        EX_regwriteaddr = cur.ra;
        EX_aluresult    = cur.alu;
        EX_memread      = cur.mr;
    endtask

    // One clock of upstream pipeline plus data memory.
    task automatic step();
        wb_t w;
        @(negedge clk);
        rst = 1'b0;
        if (need_new) begin
            cur = (instr_q.size() != 0) ? instr_q.pop_front() : rand_instr(1'b0);
            apply_cur();
            need_new = 1'b0;
        end
        if (mem_req) begin
            pend      = 1'b1;
            pend_addr = mem_addr;
            pend_cnt  = (force_lat >= 0) ? force_lat : $urandom_range(0, 3);
        end
        if (pend && mem_auto && pend_cnt == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_fn(pend_addr);
            pend       = 1'b0;
        end else begin
            if (pend && mem_auto) pend_cnt--;
            // Stray responses with no load pending must be ignored.
            mem_rvalid = (!pend && !mem_req) ? ($urandom_range(0, 7) == 0) : 1'b0;
            mem_rdata  = $urandom;
        end
        if (late_rv) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hBAD0_BAD0;
            late_rv    = 1'b0;
        end
        #1;
        if (mem_stall) stall_cnt++;
        if (!mem_stall) begin
            if (cur.v && cur.mr) req_q.push_back(cur.alu);
            if (cur.v && cur.rw && !(ZS && cur.ra == '0)) begin
                w.addr   = cur.ra;
                w.data   = cur.mr ? mem_fn(cur.alu) : cur.alu;
                w.m2r    = cur.mr;
                w.at_cyc = cyc + 2;
                w.exact  = !cur.mr;
                wb_q.push_back(w);
            end
            exp_rw   = cur.v && cur.rw && !(ZS && cur.ra == '0);
            exp_ra   = cur.ra;
            exp_rd   = cur.alu;
            exp_ld   = cur.v && cur.mr;
            need_new = 1'b1;
        end
    endtask

    task automatic drain(input int bound);
        int t = 0;
        do begin
            step();
            t++;
        end while ((instr_q.size() != 0 || wb_q.size() != 0 || req_q.size() != 0 || !need_new)
                   && t < bound);
        checks++;
        if (instr_q.size() != 0 || wb_q.size() != 0 || req_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: left instr=%0d wb=%0d req=%0d, required all 0",
                     instr_q.size(), wb_q.size(), req_q.size());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        mem_rvalid = 1'b0;
        cur        = rand_instr(1'b0);
        apply_cur();
        need_new   = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        wb_q.delete();
        req_q.delete();
        pend   = 1'b0;
        exp_rw = 1'b0; exp_ra = '0; exp_rd = '0; exp_ld = 1'b0;
        checks++;
        if ({mem_req, mem_addr, mem_stall, EX_MEM_regwrite, EX_MEM_regwriteaddr,
             EX_MEM_regwritedata, EX_MEM_isload, MEM_WB_regwrite, MEM_WB_regwriteaddr,
             MEM_WB_aluresult, MEM_WB_memreaddata, MEM_WB_memtoreg,
             rf_we, rf_waddr, rf_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b addr=%h stall=%b exm=%b/%h/%h/%b rf=%b/%h/%h, required all 0",
                     mem_req, mem_addr, mem_stall, EX_MEM_regwrite, EX_MEM_regwriteaddr,
                     EX_MEM_regwritedata, EX_MEM_isload, rf_we, rf_waddr, rf_wdata);
        end
    endtask

    // Monitor: compares the bypass sources and pops the scoreboard.
    initial begin
        wb_t           w;
        logic [DW-1:0] a;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                checks++;
                if ({EX_MEM_regwrite, EX_MEM_regwriteaddr, EX_MEM_regwritedata, EX_MEM_isload}
                    !== {exp_rw, exp_ra, exp_rd, exp_ld}) begin
                    errors++;
                    $display("FAIL ex_mem: got rw=%b ra=%0d d=%h ld=%b, required rw=%b ra=%0d d=%h ld=%b",
                             EX_MEM_regwrite, EX_MEM_regwriteaddr, EX_MEM_regwritedata,
                             EX_MEM_isload, exp_rw, exp_ra, exp_rd, exp_ld);
                end
                if (mem_req) begin
                    checks++;
                    if (req_q.size() == 0) begin
                        errors++;
                        $display("FAIL mem_req: unexpected request addr=%h, required none", mem_addr);
                    end else begin
                        a = req_q.pop_front();
                        if (mem_addr !== a) begin
                            errors++;
                            $display("FAIL mem_addr: got %h, required %h", mem_addr, a);
                        end
                    end
                end
                if (rf_we) begin
                    checks++;
                    if (wb_q.size() == 0) begin
                        errors++;
                        $display("FAIL rf_write: unexpected write $%0d=%h, required none",
                                 rf_waddr, rf_wdata);
                    end else begin
                        w = wb_q.pop_front();
                        if (rf_waddr !== w.addr || rf_wdata !== w.data || MEM_WB_memtoreg !== w.m2r) begin
                            errors++;
                            $display("FAIL rf_write: got $%0d=%h m2r=%b, required $%0d=%h m2r=%b",
                                     rf_waddr, rf_wdata, MEM_WB_memtoreg, w.addr, w.data, w.m2r);
                        end
                        if (w.exact ? (cyc != w.at_cyc) : (cyc < w.at_cyc)) begin
                            errors++;
                            $display("FAIL rf_latency: write at cycle %0d, required %s%0d",
                                     cyc, w.exact ? "" : ">=", w.at_cyc);
                        end
                    end
                end
            end
        end
    end

    initial begin
        do_reset();

        // ALU op to $5.
        stall_cnt = 0;
        instr_q.push_back(mk(1'b1, 1'b1, 5'd5, 32'h0000_1234, 1'b0));
        drain(50);
        checks++;
        if (stall_cnt != 0) begin
            errors++;
            $display("FAIL alu_stall: got %0d stall cycles, required 0", stall_cnt);
        end

        // Load with same-cycle response.
        force_lat = 0; stall_cnt = 0;
        instr_q.push_back(mk(1'b1, 1'b1, 5'd7, 32'h0000_0100, 1'b1));
        drain(50);
        checks++;
        if (stall_cnt != 0) begin
            errors++;
            $display("FAIL load0_stall: got %0d stall cycles, required 0", stall_cnt);
        end

        // Load answered three cycles after the request.
        force_lat = 3; stall_cnt = 0;
        instr_q.push_back(mk(1'b1, 1'b1, 5'd8, 32'h0000_0104, 1'b1));
        drain(50);
        checks++;
        if (stall_cnt != 3) begin
            errors++;
            $display("FAIL load3_stall: got %0d stall cycles, required 3", stall_cnt);
        end

        // Back-to-back loads, one-cycle memory.
        force_lat = 1; stall_cnt = 0;
        instr_q.push_back(mk(1'b1, 1'b1, 5'd10, 32'h0000_0200, 1'b1));
        instr_q.push_back(mk(1'b1, 1'b1, 5'd11, 32'h0000_0204, 1'b1));
        drain(50);
        checks++;
        if (stall_cnt != 2) begin
            errors++;
            $display("FAIL b2b_stall: got %0d stall cycles, required 2", stall_cnt);
        end

        // Write to $0.
        force_lat = -1;
        instr_q.push_back(mk(1'b1, 1'b1, 5'd0, 32'h0000_0055, 1'b0));
        drain(50);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) instr_q.push_back(rand_instr(1'b1));
        drain(4000);

        // Reset while a load waits, then a late response.
        mem_auto = 1'b0;
        instr_q.push_back(mk(1'b1, 1'b1, 5'd9, 32'h0000_0300, 1'b1));
        repeat (4) step();
        checks++;
        if (mem_stall !== 1'b1) begin
            errors++;
            $display("FAIL wait_stall: got %b, required 1", mem_stall);
        end
        do_reset();
        mem_auto = 1'b1;
        late_rv  = 1'b1;
        repeat (6) step();
        checks++;
        if (wb_q.size() != 0 || req_q.size() != 0) begin
            errors++;
            $display("FAIL post_reset: queued wb=%0d req=%0d, required 0", wb_q.size(), req_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_mem_wb_bypass_source.md
# ex_mem_wb_bypass_source

Producer end of the ID-stage forwarding network: registers the EX result through the EX/MEM and MEM/WB pipeline latches and publishes every bypass source the ID forwarding unit consumes (EX_MEM_* and MEM_WB_* values plus the load flag). It performs loads over a single-outstanding request/response data-memory handshake, stalls the front of the pipeline while a load is pending, and drives the register-file write port from MEM/WB.

## Interface
- DATA_W, 32, datapath and memory word width
- REG_AW, 5, register address width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- EX_valid  in  1  EX holds a real instruction (0 = bubble)
- EX_regwrite  in  1  instruction writes a register
- EX_regwriteaddr  in  REG_AW  destination register
- EX_aluresult  in  DATA_W  ALU result; also the load address
- EX_memread  in  1  instruction is a load
- mem_req  out  1  load request strobe
- mem_addr  out  DATA_W  load address
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DATA_W  read data
- mem_stall  out  1  hold PC/IF/ID/EX this cycle
- EX_MEM_regwrite / EX_MEM_regwriteaddr / EX_MEM_regwritedata  out  1/REG_AW/DATA_W  EX/MEM bypass source
- EX_MEM_isload  out  1  EX/MEM holds a load (data not forwardable)
- MEM_WB_regwrite / MEM_WB_regwriteaddr  out  1/REG_AW  MEM/WB destination
- MEM_WB_aluresult / MEM_WB_memreaddata  out  DATA_W  MEM/WB values
- MEM_WB_memtoreg  out  1  select memreaddata over aluresult
- rf_we / rf_waddr / rf_wdata  out  1/REG_AW/DATA_W  register-file write port

## Operation
- EX/MEM captures {EX_valid&EX_regwrite, addr, aluresult, EX_valid&EX_memread} when mem_stall=0; holds otherwise.
- EX_MEM_regwritedata is always the ALU result; for loads EX_MEM_isload=1 tells ID to stall instead of forwarding.
- Load FSM, states IDLE, WAIT:
  - IDLE, EX/MEM not a load: mem_req=0, mem_stall=0.
  - IDLE, EX/MEM load: mem_req=1, mem_addr=EX_MEM_regwritedata. mem_rvalid same cycle -> capture mem_rdata, advance, stay IDLE, mem_stall=0. Else -> WAIT, mem_stall=1.
  - WAIT: mem_req=0, mem_addr held. mem_stall=!mem_rvalid. mem_rvalid -> capture, advance, -> IDLE.
- MEM/WB loads from EX/MEM when EX/MEM advances; memtoreg=isload, memreaddata=captured data (0 for non-loads). When EX/MEM cannot advance, MEM/WB loads a bubble (regwrite=0, all fields 0) so each instruction writes back exactly once.
- rf_we=MEM_WB_regwrite, rf_waddr=MEM_WB_regwriteaddr, rf_wdata=memtoreg ? memreaddata : aluresult (combinational).
- mem_rvalid outside a pending load is ignored.

## Timing
- All pipeline outputs and FSM state registered; mem_req, mem_addr, mem_stall, rf_* combinational from state, registers and mem_rvalid.
- Latency EX->rf write: 2 cycles for ALU ops; 2 + N for a load whose mem_rvalid arrives N cycles after mem_req.
- mem_req is a one-cycle pulse per load; never two requests outstanding.
- Back-to-back loads: second load enters EX/MEM the cycle after the first advances; its request issues that cycle.
- Reset: every output 0, FSM IDLE. Reset during WAIT abandons the load; a late mem_rvalid afterwards is ignored.

## Configuration
- BYPASS_ZERO_SUPPRESS_EN defined: writes to register 0 are stripped at EX/MEM capture (EX_MEM_regwrite=0 when EX_regwriteaddr==0), so $0 is never forwarded or written.
- Undefined: regwrite passes unchanged; $0 suppression is the register file's responsibility.

## Structure
- Shared package: DATA_W, REG_AW defaults; load-FSM state enum (IDLE, WAIT); bubble constant for the MEM/WB record.
- One sub-module: ex_mem_load_fsm (state, mem_req, mem_stall, read-data capture strobe); pipeline registers stay in the top.

## Test plan
- ALU add to $5 = 0x0000_1234, no stall -> EX_MEM_* valid cycle+1, rf_we=1 rf_waddr=5 rf_wdata=0x1234 cycle+2, mem_stall never 1.
- Load $7 addr 0x100, mem_rvalid same cycle with 0xDEAD_BEEF -> mem_req one cycle, mem_stall=0, rf_wdata=0xDEADBEEF, MEM_WB_memtoreg=1.
- Load with mem_rvalid 3 cycles late -> mem_stall=1 for 3 cycles, EX/MEM held, MEM/WB bubbles (rf_we=0) 3 cycles, then single write of data.
- Two consecutive loads, 1-cycle memory latency -> exactly two mem_req pulses, correct addresses, two writebacks in order.
- rst asserted in WAIT, mem_rvalid one cycle after -> all outputs 0, IDLE, no rf write.
- Write to $0 of 0x55: macro defined -> EX_MEM_regwrite=0, rf_we=0; undefined -> rf_we=1, rf_waddr=0.
